sram_rd_arbiter: RTL and testbench

- Round-robin read arbiter that sits directly upstream of the 16:1 SRAM port mux.
- Takes up to 16 read requesters and picks one per cycle.
- Drives the mux's 5-bit select and read enable. Requesters drive their own address lines straight into the mux.
- Tracks the SRAM read latency and returns read data with a one-hot valid to the requester that issued it.

---
 rtl/sram_rd_arbiter_pkg.sv | 16 +
 rtl/sram_rd_arbiter_if.sv | 23 ++
 rtl/sram_rd_arbiter_rr_pick16.sv | 22 ++
 rtl/sram_rd_arbiter.sv | 123 ++++++++++++
 tb/tb_sram_rd_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_rd_arbiter_pkg.sv
// Shared constants and tag type for the SRAM read arbiter.
// D_width normally comes from define.svh; a 32-bit fallback keeps the slice standalone.
`ifndef D_width
`define D_width 32
`endif

package arb_pkg;
  localparam int unsigned NUM_REQ      = 16;
  localparam int unsigned MAX_SRAM_LAT = 4;
  localparam logic [4:0]  SEL_IDLE     = 5'd31;

  typedef struct packed {
    logic       valid;
    logic [3:0] id;
  } rd_tag_t;
endpackage

// File: rtl/sram_rd_arbiter_if.sv
// Requester/mux-facing bundle of the SRAM read arbiter; master is the arbiter side.
interface sram_rd_arbiter_if #(
  parameter int unsigned D_W = `D_width
) ();
  logic [arb_pkg::NUM_REQ-1:0] req_i;
  logic                        hold_i;
  logic [arb_pkg::NUM_REQ-1:0] gnt_o;
  logic [4:0]                  sel_o;
  logic                        r_enable_o;
  logic [D_W-1:0]              rdata_i;
  logic [arb_pkg::NUM_REQ-1:0] rvalid_o;
  logic [D_W-1:0]              rdata_o;

  modport master (
    input  req_i, hold_i, rdata_i,
    output gnt_o, sel_o, r_enable_o, rvalid_o, rdata_o
  );

  modport slave (
    output req_i, hold_i, rdata_i,
    input  gnt_o, sel_o, r_enable_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sram_rd_arbiter_rr_pick16.sv
// Rotating priority encoder: first set bit of eligible searching upward from ptr, wrapping 15->0.
module rr_pick16 (
  input  logic [15:0] eligible,
  input  logic [3:0]  ptr,
  output logic        found,
  output logic [3:0]  idx
);
  logic [3:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/sram_rd_arbiter.sv
// Round-robin read arbiter in front of the 16:1 SRAM port mux, with read-latency tag tracking.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module sram_rd_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 16,
  parameter int unsigned SRAM_LAT = 1,
  parameter int unsigned D_W      = `D_width
) (
  input logic                clk,
  input logic                rst,
  sram_rd_arbiter_if.master  bus
`ifdef ARB_PERF_CNT_EN
  ,
  input  logic               perf_clr_i,
  output logic [31:0]        perf_gnt_cnt_o,
  output logic [31:0]        perf_conflict_cnt_o
`endif
);
  if (NUM_REQ != 16) begin : g_bad_num_req
    $error("sram_rd_arbiter: NUM_REQ must be 16");
  end
  if (SRAM_LAT < 1 || SRAM_LAT > MAX_SRAM_LAT) begin : g_bad_lat
    $error("sram_rd_arbiter: SRAM_LAT must be 1..4");
  end

  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] win_onehot;
  logic [NUM_REQ-1:0] rvalid_c;
  logic [D_W-1:0]     rdata_c;
  logic [3:0]         id_q;
  logic [3:0]         rr_ptr;
  logic [3:0]         win_idx;
  logic               ren_q;
  logic               win_found;
  logic               win;
  rd_tag_t            tag_q [SRAM_LAT];
  rd_tag_t            tag_out;

  // Last cycle's winner is masked out so its address phase completes before it can win again.
  assign eligible = bus.req_i & ~gnt_q;
  assign win      = win_found & ~bus.hold_i;

  rr_pick16 u_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .found    (win_found),
    .idx      (win_idx)
  );

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q  <= '0;
      id_q   <= '0;
      ren_q  <= 1'b0;
      rr_ptr <= '0;
    end else if (win) begin
      gnt_q  <= win_onehot;
      id_q   <= win_idx;
      ren_q  <= 1'b1;
      rr_ptr <= win_idx + 4'd1;
    end else begin
      gnt_q  <= '0;
      id_q   <= '0;
      ren_q  <= 1'b0;
    end
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.r_enable_o = ren_q;
  assign bus.sel_o      = ren_q ? {1'b0, id_q} : SEL_IDLE;

  // Stage 0 captures the access cycle; the last stage lines up with valid SRAM Q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SRAM_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {ren_q, id_q};
      for (int unsigned i = 1; i < SRAM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[SRAM_LAT-1];

  always_comb begin
    rvalid_c = '0;
    rdata_c  = '0;
    if (tag_out.valid) begin
      rvalid_c[tag_out.id] = 1'b1;
      rdata_c              = bus.rdata_i;
    end
  end

  assign bus.rvalid_o = rvalid_c;
  assign bus.rdata_o  = rdata_c;

`ifdef ARB_PERF_CNT_EN
  logic conflict;

  assign conflict = ($countones(eligible) >= 2) && !bus.hold_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_gnt_cnt_o      <= '0;
      perf_conflict_cnt_o <= '0;
    end else if (perf_clr_i) begin
      perf_gnt_cnt_o      <= '0;
      perf_conflict_cnt_o <= '0;
    end else begin
      if (ren_q && perf_gnt_cnt_o != '1)
        perf_gnt_cnt_o <= perf_gnt_cnt_o + 32'd1;
      if (conflict && perf_conflict_cnt_o != '1)
        perf_conflict_cnt_o <= perf_conflict_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Self-checking bench for sram_rd_arbiter: directed table, corner sequences and randomized traffic
// against a queue-based reference model. Perf counters are checked when ARB_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_sram_rd_arbiter #(
  parameter int unsigned SRAM_LAT = 1
);
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_rd_arbiter_if #(.D_W(DW)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic        perf_clr;
  logic        clr_next;
  logic [31:0] perf_gnt;
  logic [31:0] perf_conf;
  int unsigned m_pg, m_pc;
`endif

  sram_rd_arbiter #(
    .NUM_REQ  (16),
    .SRAM_LAT (SRAM_LAT),
    .D_W      (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_clr_i          (perf_clr),
    .perf_gnt_cnt_o      (perf_gnt),
    .perf_conflict_cnt_o (perf_conf)
`endif
  );

  // Requester-owned addresses and a behavioural SRAM behind the mux
  logic [7:0]    addr [16];
  logic [DW-1:0] qp   [SRAM_LAT];

  function automatic logic [31:0] mem_f(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, a + 8'd3};
  endfunction

  always @(posedge clk) begin
    qp[0] <= bus.r_enable_o ? mem_f(addr[bus.sel_o[3:0]]) : 32'hDEAD_BEEF;
    for (int i = 1; i < int'(SRAM_LAT); i++) qp[i] <= qp[i-1];
  end
  assign bus.rdata_i = qp[SRAM_LAT-1];

  // Reference model state
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } ret_t;

  logic [15:0] m_gnt;
  logic [4:0]  m_sel;
  logic        m_ren;
  int          m_ptr;
  int          cyc;
  ret_t        pend[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs against the model, advance the model.
  task automatic cycle(input logic [15:0] req, input logic hold);
    logic [15:0] elig;
    logic [15:0] exp_rv;
    logic [31:0] exp_rd;
    int          k;
    @(negedge clk);
    bus.req_i  = req;
    bus.hold_i = hold;
`ifdef ARB_PERF_CNT_EN
    perf_clr   = clr_next;
`endif
    for (int i = 0; i < 16; i++)
      if (!m_gnt[i] && ($urandom_range(0, 3) == 0)) addr[i] = 8'($urandom);
    if (m_ren)
      pend.push_back('{due: cyc + int'(SRAM_LAT), id: int'(m_sel), data: mem_f(addr[m_sel[3:0]])});
    #1;
    chk("gnt_o", 64'(bus.gnt_o), 64'(m_gnt));
    chk("sel_o", 64'(bus.sel_o), 64'(m_sel));
    chk("r_enable_o", 64'(bus.r_enable_o), 64'(m_ren));
    exp_rv = '0;
    exp_rd = '0;
    foreach (pend[j]) begin
      if (pend[j].due == cyc) begin
        exp_rv[pend[j].id] = 1'b1;
        exp_rd             = pend[j].data;
      end
    end
    chk("rvalid_o", 64'(bus.rvalid_o), 64'(exp_rv));
    chk("rdata_o", 64'(bus.rdata_o), 64'(exp_rd));
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());

    elig = req & ~m_gnt;
`ifdef ARB_PERF_CNT_EN
    chk("perf_gnt_cnt", 64'(perf_gnt), 64'(m_pg));
    chk("perf_conflict_cnt", 64'(perf_conf), 64'(m_pc));
    if (m_ren) m_pg++;
    if ($countones(elig) >= 2 && !hold) m_pc++;
    if (clr_next) begin
      m_pg = 0;
      m_pc = 0;
    end
`endif
    k = -1;
    if (!hold) begin
      for (int i = 0; i < 16; i++) begin
        int c;
        c = (m_ptr + i) % 16;
        if (k < 0 && elig[c]) k = c;
      end
    end
    if (k >= 0) begin
      m_gnt = 16'(1) << k;
      m_sel = 5'(k);
      m_ren = 1'b1;
      m_ptr = (k + 1) % 16;
    end else begin
      m_gnt = '0;
      m_sel = 5'd31;
      m_ren = 1'b0;
    end
    cyc++;
  endtask

  // Asserts reset between edges and checks outputs clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst        = 1'b1;
    bus.req_i  = '0;
    bus.hold_i = 1'b0;
    #1;
    chk("rst_gnt_o", 64'(bus.gnt_o), 64'h0);
    chk("rst_sel_o", 64'(bus.sel_o), 64'd31);
    chk("rst_r_enable_o", 64'(bus.r_enable_o), 64'h0);
    chk("rst_rvalid_o", 64'(bus.rvalid_o), 64'h0);
    chk("rst_rdata_o", 64'(bus.rdata_o), 64'h0);
`ifdef ARB_PERF_CNT_EN
    chk("rst_perf_gnt", 64'(perf_gnt), 64'h0);
    chk("rst_perf_conf", 64'(perf_conf), 64'h0);
    m_pg = 0;
    m_pc = 0;
`endif
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_gnt = '0;
    m_sel = 5'd31;
    m_ren = 1'b0;
    m_ptr = 0;
    pend.delete();
  endtask

  typedef struct {
    logic [15:0] req;
    logic        hold;
    logic [15:0] gnt;
    logic [4:0]  sel;
    logic        ren;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int seen;
    logic [15:0] rq;

    bus.req_i  = '0;
    bus.hold_i = 1'b0;
    for (int i = 0; i < 16; i++) addr[i] = 8'(i * 17);
`ifdef ARB_PERF_CNT_EN
    perf_clr = 1'b0;
    clr_next = 1'b0;
    m_pg     = 0;
    m_pc     = 0;
`endif
    cyc = 0;

    tbl[0]  = '{16'h0001, 1'b0, 16'h0000, 5'd31, 1'b0};
    tbl[1]  = '{16'h0001, 1'b0, 16'h0001, 5'd0,  1'b1};
    tbl[2]  = '{16'h0001, 1'b0, 16'h0000, 5'd31, 1'b0};
    tbl[3]  = '{16'h8001, 1'b0, 16'h0001, 5'd0,  1'b1};
    tbl[4]  = '{16'h8001, 1'b0, 16'h8000, 5'd15, 1'b1};
    tbl[5]  = '{16'h0010, 1'b1, 16'h0001, 5'd0,  1'b1};
    tbl[6]  = '{16'h0010, 1'b1, 16'h0000, 5'd31, 1'b0};
    tbl[7]  = '{16'h0010, 1'b0, 16'h0000, 5'd31, 1'b0};
    tbl[8]  = '{16'h0000, 1'b0, 16'h0010, 5'd4,  1'b1};
    tbl[9]  = '{16'h0022, 1'b0, 16'h0000, 5'd31, 1'b0};
    tbl[10] = '{16'h0022, 1'b0, 16'h0020, 5'd5,  1'b1};
    tbl[11] = '{16'h0022, 1'b0, 16'h0002, 5'd1,  1'b1};
    tbl[12] = '{16'h0000, 1'b0, 16'h0020, 5'd5,  1'b1};
    tbl[13] = '{16'h0000, 1'b0, 16'h0000, 5'd31, 1'b0};

    // Idle after reset
    do_reset();
    for (int c = 0; c < 20; c++) cycle(16'h0000, 1'b0);

    // Directed table: single requester, 15->0 wrap, hold, pointer rotation
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].req, tbl[i].hold);
      chk("tbl_gnt", 64'(bus.gnt_o), 64'(tbl[i].gnt));
      chk("tbl_sel", 64'(bus.sel_o), 64'(tbl[i].sel));
      chk("tbl_ren", 64'(bus.r_enable_o), 64'(tbl[i].ren));
    end
    for (int c = 0; c < 6; c++) cycle(16'h0000, 1'b0);

    // Lone requester: granted every second cycle, data 1+SRAM_LAT after each request cycle
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cycle(16'h0001, 1'b0);
      chk("single_gnt", 64'(bus.gnt_o[0]), 64'(c % 2 == 1));
      chk("single_rvalid", 64'(bus.rvalid_o[0]),
          64'((c >= 1 + int'(SRAM_LAT)) && ((c - 1 - int'(SRAM_LAT)) % 2 == 0)));
    end

    // All requesting: strict rotation, one grant per cycle
    do_reset();
    for (int c = 0; c < 34; c++) begin
      cycle(16'hFFFF, 1'b0);
      if (c >= 1) begin
        chk("rr_order", 64'(bus.sel_o), 64'((c - 1) % 16));
        chk("rr_ren", 64'(bus.r_enable_o), 64'h1);
      end
    end
    for (int c = 0; c < 6; c++) cycle(16'h0000, 1'b0);

    // Exact latency of a single read
    do_reset();
    for (int c = 0; c <= int'(SRAM_LAT) + 3; c++) begin
      cycle((c == 0) ? 16'h0001 : 16'h0000, 1'b0);
      chk("latency_rvalid", 64'(bus.rvalid_o[0]), 64'(c == 1 + int'(SRAM_LAT)));
    end

    // Hold with an in-flight read to requester 4 and a pending re-request
    do_reset();
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      cycle((c <= 4) ? 16'h0010 : 16'h0000, (c >= 1 && c <= 3));
      if (c >= 2 && c <= 4) chk("hold_no_gnt", 64'(bus.gnt_o), 64'h0);
      if (c == 5) chk("hold_release_gnt", 64'(bus.gnt_o), 64'h0010);
      if (c >= 1 && c <= 1 + int'(SRAM_LAT) && bus.rvalid_o[4]) seen++;
    end
    chk("hold_inflight_rv", 64'(seen), 64'd1);

    // Randomized traffic with a mid-flight reset
    do_reset();
    for (int c = 0; c < 600; c++) begin
      case ((c / 100) % 3)
        0:       rq = 16'($urandom) | 16'($urandom);
        1:       rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: rq = 16'(1) << $urandom_range(0, 15);
      endcase
`ifdef ARB_PERF_CNT_EN
      clr_next = (c == 150);
`endif
      if (c == 300) do_reset();
      cycle(rq, ($urandom_range(0, 7) == 0));
    end
`ifdef ARB_PERF_CNT_EN
    clr_next = 1'b0;
`endif
    for (int c = 0; c < 8; c++) cycle(16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
